// File: rtl/imem_program_loader_if.sv
// Byte-stream valid/ready handshake from the host/UART receiver into the program loader.
// The sender drives data/valid (master) and the loader answers with ready (slave).
interface imem_program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Loads a program from a byte stream into instruction memory, big-endian per 32-bit word,
// then releases the memory to run mode and lets the CPU out of hold.
module imem_program_loader #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W:0]       word_count_i,
    imem_program_loader_if.slave  rx,
    output logic                  init_mode_o,
    output logic [ADDR_W-1:0]     init_address_o,
    output logic [31:0]           init_instruction_o,
    output logic                  write_enable_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  load_done_o,
    output logic                  load_error_o,
    output logic [ADDR_W:0]       words_written_o
);
    localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   MaxCount  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              start_ok;

    assign start_ok = (word_count_i != '0) && (word_count_i <= MaxCount);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        words_d    = words_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wr_data_d  = wr_data_q;
        timer_d    = timer_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    if (start_ok) begin
                        count_d    = word_count_i;
                        words_d    = '0;
                        byte_idx_d = '0;
                        addr_d     = '0;
                        timer_d    = '0;
                        state_d    = StRecv;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StRecv: begin
                // An accepted byte wins over a timeout reached in the same cycle.
                if (rx.rx_valid) begin
                    timer_d    = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    asm_d      = {asm_q[15:0], rx.rx_data};
                    if (byte_idx_q == 2'd3) begin
                        // Write port registers only change here, so they hold outside WRITE.
                        wr_addr_d = addr_q;
                        wr_data_d = {asm_q, rx.rx_data};
                        state_d   = StWrite;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = (words_d == count_q) ? StDone : StRecv;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_data_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_data_q  <= wr_data_d;
            timer_q    <= timer_d;
        end
    end

    assign rx.rx_ready         = (state_q == StRecv);
    assign busy_o              = (state_q == StRecv) || (state_q == StWrite);
    assign init_mode_o         = busy_o;
    assign write_enable_o      = (state_q == StWrite);
    assign cpu_hold_o          = (state_q != StDone);
    assign load_done_o         = (state_q == StDone);
    assign load_error_o        = (state_q == StErr);
    assign init_address_o      = wr_addr_q;
    assign init_instruction_o  = wr_data_q;
    assign words_written_o     = words_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized bench for imem_program_loader: expected memory writes are rebuilt from the
// bytes sent (word i = bytes 4i..4i+3 big-endian, at address i) and compared to a write log.
module tb_imem_program_loader;
    localparam int unsigned AW    = 12;
    localparam int unsigned TO    = 16;
    localparam int unsigned Depth = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic          init_mode, write_enable, cpu_hold, busy, load_done, load_error;
    logic [AW-1:0] init_address;
    logic [31:0]   init_instruction;
    logic [AW:0]   words_written;

    imem_program_loader_if rx_if ();

    imem_program_loader #(
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start),
        .word_count_i       (word_count),
        .rx                 (rx_if),
        .init_mode_o        (init_mode),
        .init_address_o     (init_address),
        .init_instruction_o (init_instruction),
        .write_enable_o     (write_enable),
        .cpu_hold_o         (cpu_hold),
        .busy_o             (busy),
        .load_done_o        (load_done),
        .load_error_o       (load_error),
        .words_written_o    (words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write log, sampled mid-cycle.
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            we_bad = 0;

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            obs_addr.push_back(init_address);
            obs_data.push_back(init_instruction);
            if (rx_if.rx_ready !== 1'b0 || init_mode !== 1'b1) we_bad++;
        end
    end

    logic [7:0] tx_bytes[$];
    logic [7:0] dir_bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start(input int n);
        logic [AW:0] c;
        c = n[AW:0];
        tick();
        start      = 1'b1;
        word_count = c;
    endtask

    // Sends tx_bytes[0..n_send-1]; the gap counts only cycles in which the loader listens.
    task automatic feed(input int n_send, input int gap_lo, input int gap_hi, input int inj_at,
                        output int sent);
        sent = 0;
        for (int b = 0; b < n_send; b++) begin
            int gap   = int'($urandom_range(gap_hi, gap_lo));
            int guard = 0;
            bit ok    = 1'b0;
            while (gap > 0 && guard < 200) begin
                tick();
                rx_if.rx_valid = 1'b0;
                guard++;
                if (rx_if.rx_ready === 1'b1) gap--;
            end
            while (!ok && guard < 200) begin
                tick();
                guard++;
                rx_if.rx_valid = 1'b1;
                rx_if.rx_data  = tx_bytes[b];
                if (b == inj_at) begin
                    start      = 1'b1;
                    word_count = 13'($urandom_range(4096, 1));
                end
                if (rx_if.rx_ready === 1'b1) ok = 1'b1;
            end
            if (!ok) break;
            sent++;
        end
        tick();
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic wait_end(output bit ended);
        ended = 1'b0;
        for (int i = 0; i < 64 && !ended; i++) begin
            tick();
            if (load_done === 1'b1 || load_error === 1'b1) ended = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag, input int nwords);
        logic [31:0] e;
        check_eq({tag, "_nwr"}, obs_addr.size(), nwords);
        for (int i = 0; i < nwords && i < obs_addr.size(); i++) begin
            e = {tx_bytes[4*i], tx_bytes[4*i+1], tx_bytes[4*i+2], tx_bytes[4*i+3]};
            check_eq($sformatf("%s_addr%0d", tag, i), obs_addr[i], i % Depth);
            check_eq($sformatf("%s_data%0d", tag, i), obs_data[i], e);
        end
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic check_idle_outs(input string tag, input bit hold, input bit done,
                                   input bit err);
        check_eq({tag, "_init_mode"}, init_mode, 0);
        check_eq({tag, "_we"}, write_enable, 0);
        check_eq({tag, "_rx_ready"}, rx_if.rx_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cpu_hold"}, cpu_hold, hold);
        check_eq({tag, "_done"}, load_done, done);
        check_eq({tag, "_error"}, load_error, err);
    endtask

    task automatic run_load(input string tag, input int nwords, input int gap_lo,
                            input int gap_hi, input int inj_at, input bit fill_rand);
        int sent;
        bit ended;
        if (fill_rand) begin
            tx_bytes.delete();
            repeat (4 * nwords) tx_bytes.push_back(8'($urandom));
        end
        do_start(nwords);
        feed(4 * nwords, gap_lo, gap_hi, inj_at, sent);
        check_eq({tag, "_sent"}, sent, 4 * nwords);
        wait_end(ended);
        check_eq({tag, "_ended"}, ended, 1);
        check_idle_outs(tag, 1'b0, 1'b1, 1'b0);
        check_eq({tag, "_words_written"}, words_written, nwords);
        check_eq({tag, "_we_cycle"}, we_bad, 0);
        check_writes(tag, nwords);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  sent;
        int  k;
        bit  ended;
        rst            = 1'b1;
        start          = 1'b0;
        word_count     = '0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = '0;
        #3;
        check_idle_outs("reset", 1'b1, 1'b0, 1'b0);
        check_eq("reset_addr", init_address, 0);
        check_eq("reset_instr", init_instruction, 0);
        check_eq("reset_words", words_written, 0);
        @(negedge clk);
        rst = 1'b0;

        tx_bytes.delete();
        foreach (dir_bytes[i]) tx_bytes.push_back(dir_bytes[i]);
        run_load("held", 2, 0, 0, -1, 1'b0);
        check_eq("held_addr_hold", init_address, 1);
        check_eq("held_instr_hold", init_instruction, 32'h0000000C);

        run_load("toggle", 2, 1, 1, -1, 1'b0);

        do_start(0);
        tick();
        check_idle_outs("wc0", 1'b1, 1'b0, 1'b1);
        check_writes("wc0", 0);
        do_start(4097);
        tick();
        check_idle_outs("wc4097", 1'b1, 1'b0, 1'b1);
        check_writes("wc4097", 0);

        // Two bytes then silence: error lands TO edges after the last accepting edge.
        tx_bytes.delete();
        repeat (4) tx_bytes.push_back(8'($urandom));
        do_start(1);
        feed(2, 0, 0, -1, sent);
        check_eq("to_sent", sent, 2);
        k = 1;
        while (load_error !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check_eq("to_edges", k - 1, TO);
        check_idle_outs("to", 1'b1, 1'b0, 1'b1);
        check_eq("to_words", words_written, 0);
        check_writes("to", 0);

        // Reset with word 0 written and three bytes of word 1 pending.
        tx_bytes.delete();
        repeat (12) tx_bytes.push_back(8'($urandom));
        do_start(3);
        feed(7, 0, 0, -1, sent);
        check_eq("rst_sent", sent, 7);
        #2 rst = 1'b1;
        #1;
        check_idle_outs("rst_mid", 1'b1, 1'b0, 1'b0);
        check_eq("rst_mid_words", words_written, 0);
        check_eq("rst_mid_addr", init_address, 0);
        check_eq("rst_mid_instr", init_instruction, 0);
        check_writes("rst_part", 1);
        @(negedge clk);
        rst = 1'b0;
        run_load("after_rst", 2, 0, 0, -1, 1'b1);

        run_load("inj", 3, 0, 2, 5, 1'b1);
        run_load("gap15", 2, TO - 1, TO - 1, -1, 1'b1);

        for (int it = 0; it < 6; it++) begin
            int n;
            int inj;
            n   = int'($urandom_range(6, 1));
            inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4 * n - 1, 0)) : -1;
            run_load($sformatf("rand%0d", it), n, 0, int'($urandom_range(8, 0)), inj, 1'b1);
        end

        run_load("full", Depth, 0, 0, -1, 1'b1);
        check_eq("full_addr_hold", init_address, Depth - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
Sequences the instruction memory's initialisation port. It receives a program as a byte stream over a valid/ready handshake and assembles bytes into 32-bit words. It writes the words to consecutive word addresses, then releases the memory to run mode and releases the CPU hold. The block sits between the host/UART byte receiver and the instruction memory, and gates CPU start-up.

Parameters:
ADDR_W, 12, word-address width of instruction memory (depth = 2**ADDR_W words)
TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes before error (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled in IDLE, DONE, ERR only
word_count  input  ADDR_W+1  number of words to load, latched on accepted start; legal range 1..2**ADDR_W
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
init_mode  output  1  drives memory init_mode
init_address  output  ADDR_W  drives memory init_address (word index)
init_instruction  output  32  drives memory init_instruction
write_enable  output  1  drives memory write_enable
cpu_hold  output  1  1 = hold CPU in reset/stall
busy  output  1  1 in RECV or WRITE
load_done  output  1  sticky success flag
load_error  output  1  sticky error flag
words_written  output  ADDR_W+1  count of words written in current/last load

Behaviour:
- States: IDLE, RECV, WRITE, DONE, ERR.
- Reset (asserts immediately, no clock needed): state IDLE. All outputs 0 except cpu_hold=1. Internal byte index, word index and timeout counter are cleared. Memory contents already written are not cleared.
- IDLE/DONE/ERR with start=1:
  - word_count in 1..2**ADDR_W: latch the count, clear words_written, byte index, address, timeout and both flags; set cpu_hold=1; next state RECV.
  - word_count 0 or out of range: next state ERR, load_error=1.
- start is ignored in RECV and WRITE.
- RECV:
  - init_mode=1, rx_ready=1, write_enable=0.
  - A byte is accepted on an edge where rx_valid&rx_ready.
  - Packing is big-endian: byte 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - On acceptance of byte 3: next state WRITE, byte index wraps to 0.
- WRITE (exactly one cycle):
  - init_mode=1, rx_ready=0, write_enable=1, init_address = current word index, init_instruction = assembled word. The memory captures on the edge ending this cycle.
  - On that edge: word index +1 and words_written +1. If words_written+1 == latched count, next state DONE; else RECV.
  - Latency: 4th byte accepted on edge N -> write_enable high in cycle N..N+1 -> memory written at edge N+1.
- Address wrap: with count = 2**ADDR_W, the final write is at address 2**ADDR_W-1. The word index wrapping to 0 afterwards is harmless.
- Timeout: the counter increments each RECV cycle with no accepted byte and clears on every accepted byte. Reaching TIMEOUT_CYCLES -> ERR. A byte accepted in the same cycle the limit is reached takes priority, and there is no error.
- DONE: init_mode=0, write_enable=0, rx_ready=0, cpu_hold=0, load_done=1 (held until the next accepted start or reset).
- ERR: init_mode=0, write_enable=0, rx_ready=0, cpu_hold=1, load_error=1 (held until the next accepted start or reset). A partial load leaves a partially written memory.
- init_address and init_instruction hold their last values outside WRITE. They are qualified only by write_enable.
- busy = (state==RECV || state==WRITE).
- rst asserted mid-load aborts immediately. The pending assembled word is discarded and never written.

Test Plan:
- Reset then start, word_count=2, bytes 20,08,00,05,00,00,00,0C with rx_valid held high -> WRITE at address 0 with 0x20080005, then at address 1 with 0x0000000C. Each write_enable is 1 cycle and rx_ready=0 in those cycles. Then DONE: init_mode=0, cpu_hold=0, load_done=1, words_written=2.
- Same load with rx_valid toggled 1-0-1 every cycle -> identical writes. Only handshaked bytes are counted. No error.
- start with word_count=0, and separately with word_count=4097 -> ERR, load_error=1, cpu_hold=1, no write_enable pulse.
- TIMEOUT_CYCLES=16, word_count=1, send 2 bytes then idle -> ERR exactly 16 cycles after the last accepted byte. No write occurs.
- Assert rst after 3 bytes of word 1 of 3 -> outputs return immediately to reset values. A new start then loads cleanly from address 0.
- Pulse start during RECV -> ignored. The latched count is unchanged and the load completes with the original count.
